// File: rtl/pusch_sample_framer.sv
// pusch_sample_framer: scale/saturate PUSCH time samples to DAC width, buffer them in a FIFO, and stream them with symbol/slot framing.
// Ports: clk, reset (sync, active-high); in_valid/in_r/in_i/scale_shift carry input samples (no stall);
// out_valid/out_ready/out_r/out_i form the output stream; out_sop/out_eop/out_slot_end/sym_idx give framing;
// fifo_level reports FIFO occupancy, overflow is sticky on a dropped sample, and sat_count counts clipped samples.
// Optional macro SAT_CNT_EN enables the clipped-sample counter; when it is undefined, sat_count is tied to 0.
module pusch_sample_framer #(
  parameter int WIDTH        = 26,
  parameter int OUT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYM_LEN      = 2192,
  parameter int SYM_PER_SLOT = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [WIDTH-1:0]       in_r,
  input  logic signed [WIDTH-1:0]       in_i,
  input  logic [4:0]                    scale_shift,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic signed [OUT_WIDTH-1:0]   out_r,
  output logic signed [OUT_WIDTH-1:0]   out_i,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_slot_end,
  output logic [3:0]                    sym_idx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   sat_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SYM_LEN);
  localparam logic signed [WIDTH:0] MAXV = (WIDTH+1)'(2**(OUT_WIDTH-1)-1);
  localparam logic signed [WIDTH:0] MINV = -(WIDTH+1)'(2**(OUT_WIDTH-1));
  // Round-half-up then arithmetic shift at WIDTH+1 bits so the rounding add cannot overflow;
  // the MSB of the result flags that the value was clipped.
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [WIDTH-1:0] x, input logic [4:0] sh);
    logic signed [WIDTH:0] xe, rnd, xs;
    xe  = {x[WIDTH-1], x};
    rnd = (sh == 5'd0) ? '0 : (WIDTH+1)'(1) << (sh - 5'd1);
    xs  = (xe + rnd) >>> sh;
    return (xs > MAXV) ? {1'b1, MAXV[OUT_WIDTH-1:0]} :
           (xs < MINV) ? {1'b1, MINV[OUT_WIDTH-1:0]} : {1'b0, xs[OUT_WIDTH-1:0]};
  endfunction
  logic [OUT_WIDTH:0] sc_r, sc_i;
  logic s_valid, s_clip;
  logic [OUT_WIDTH-1:0] s_r, s_i;
  assign sc_r = scale(in_r, scale_shift);
  assign sc_i = scale(in_i, scale_shift);
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_r     <= '0;
      s_i     <= '0;
      s_clip  <= 1'b0;
    end else begin
      s_valid <= in_valid;
      s_r     <= sc_r[OUT_WIDTH-1:0];
      s_i     <= sc_i[OUT_WIDTH-1:0];
      s_clip  <= sc_r[OUT_WIDTH] | sc_i[OUT_WIDTH];
    end
  end
  logic [2*OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, pop, push, drop;
  logic [CW-1:0] samp_cnt;
  assign full      = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign out_valid = fifo_level != '0;
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = s_valid & (~full | pop);
  assign drop      = s_valid & full & ~pop;
  // Gating by out_valid keeps the data outputs at 0 after reset without clearing the RAM.
  assign out_r        = out_valid ? mem[rd_ptr][2*OUT_WIDTH-1:OUT_WIDTH] : '0;
  assign out_i        = out_valid ? mem[rd_ptr][OUT_WIDTH-1:0] : '0;
  assign out_sop      = samp_cnt == '0;
  assign out_eop      = samp_cnt == CW'(SYM_LEN-1);
  assign out_slot_end = out_eop & (sym_idx == 4'(SYM_PER_SLOT-1));
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_r, s_i};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      samp_cnt   <= '0;
      sym_idx    <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      overflow   <= overflow | drop;
      if (pop) samp_cnt <= out_eop ? '0 : samp_cnt + CW'(1);
      if (pop && out_eop) sym_idx <= (sym_idx == 4'(SYM_PER_SLOT-1)) ? '0 : sym_idx + 4'd1;
    end
  end
`ifdef SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) sat_count <= '0;
    else if (push && s_clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = s_clip;
  assign sat_count   = '0;
`endif
endmodule

// File: tb/tb_pusch_sample_framer.sv
// tb_pusch_sample_framer: directed self-checking bench for pusch_sample_framer.
module tb_pusch_sample_framer;
  localparam int W = 26, OW = 16, D = 16, SL = 2192, SPS = 14;
`ifdef SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset, in_valid, out_ready, out_valid, out_sop, out_eop, out_slot_end, overflow;
  logic signed [W-1:0] in_r, in_i;
  logic [4:0] scale_shift;
  logic signed [OW-1:0] out_r, out_i;
  logic [3:0] sym_idx;
  logic [4:0] fifo_level;
  logic [15:0] sat_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pusch_sample_framer #(.WIDTH(W), .OUT_WIDTH(OW), .FIFO_DEPTH(D), .SYM_LEN(SL), .SYM_PER_SLOT(SPS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_r(in_r), .in_i(in_i), .scale_shift(scale_shift),
    .out_ready(out_ready), .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_sop(out_sop),
    .out_eop(out_eop), .out_slot_end(out_slot_end), .sym_idx(sym_idx), .fifo_level(fifo_level),
    .overflow(overflow), .sat_count(sat_count)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    tick;
    reset = 1'b0;
  endtask
  typedef struct { int sh; int xr; int xi; int er; int ei; int ec; } vec_t;
  vec_t v[9];
  initial begin
    int pops, e_data, e_sop, e_eop, e_sym, e_se, e_lvl, n_eop, n_se, err;
    int np;
    v[0] = '{4, 40, -40, 3, -2, 0};
    v[1] = '{4, 33554431, 0, 32767, 0, 1};
    v[2] = '{0, 100, -100, 100, -100, 1};
    v[3] = '{0, 40000, -40000, 32767, -32768, 2};
    v[4] = '{1, 3, -3, 2, -1, 2};
    v[5] = '{10, 5631, -5632, 5, -5, 2};
    v[6] = '{25, 33554431, -33554432, 1, -1, 2};
    v[7] = '{8, -33554432, 0, -32768, 0, 3};
    v[8] = '{2, -131072, 131068, -32768, 32767, 3};
    reset = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; scale_shift = '0; out_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sym_idx", int'(sym_idx), 0);
    chk("rst_sop", int'(out_sop), 1);
    chk("rst_eop", int'(out_eop), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    in_valid = 1'b1; in_r = W'(7); in_i = W'(-7);
    tick;
    in_valid = 1'b0;
    chk("lat_n1_valid", int'(out_valid), 0);
    tick;
    chk("lat_n2_valid", int'(out_valid), 1);
    chk("lat_n2_sop", int'(out_sop), 1);
    chk("lat_n2_data", int'(out_r), 7);
    tick;
    chk("lat_n3_valid", int'(out_valid), 0);
    for (int k = 0; k < 9; k++) begin
      scale_shift = 5'(v[k].sh); in_r = W'(v[k].xr); in_i = W'(v[k].xi); in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      chk($sformatf("scale%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("scale%0d_r", k), int'(out_r), v[k].er);
      chk($sformatf("scale%0d_i", k), int'(out_i), v[k].ei);
      chk($sformatf("scale%0d_satcnt", k), int'(sat_count), SAT_EN ? v[k].ec : 0);
      tick;
    end
    pulse_reset;
    scale_shift = '0; out_ready = 1'b1;
    np = SL * SPS + 2;
    pops = 0; e_data = 0; e_sop = 0; e_eop = 0; e_sym = 0; e_se = 0; e_lvl = 0; n_eop = 0; n_se = 0;
    for (int c = 0; c < np + 50 && pops < np; c++) begin
      in_valid = c < np; in_r = W'(c); in_i = W'(-c);
      tick;
      if (out_valid) begin
        if (int'(out_r) != pops || int'(out_i) != -pops) e_data++;
        if (out_sop != (pops % SL == 0)) e_sop++;
        if (out_eop != (pops % SL == SL - 1)) e_eop++;
        if (int'(sym_idx) != (pops / SL) % SPS) e_sym++;
        if (out_slot_end != (pops == SL * SPS - 1)) e_se++;
        n_eop += int'(out_eop);
        n_se += int'(out_slot_end);
        pops++;
      end
      if (fifo_level > 5'd1 || overflow) e_lvl++;
    end
    in_valid = 1'b0;
    tick;
    chk("frame_pops", pops, np);
    chk("frame_data_errs", e_data, 0);
    chk("frame_sop_errs", e_sop, 0);
    chk("frame_eop_errs", e_eop, 0);
    chk("frame_sym_errs", e_sym, 0);
    chk("frame_slot_end_errs", e_se, 0);
    chk("frame_eop_count", n_eop, SPS);
    chk("frame_slot_end_count", n_se, 1);
    chk("frame_level_ovf_errs", e_lvl, 0);
    pulse_reset;
    out_ready = 1'b0;
    for (int k = 0; k < D; k++) begin
      in_valid = 1'b1; in_r = W'(k); in_i = '0;
      tick;
    end
    in_valid = 1'b0;
    tick; tick;
    chk("full_level", int'(fifo_level), D);
    chk("full_overflow", int'(overflow), 0);
    chk("full_head", int'(out_r), 0);
    err = 0;
    for (int k = 0; k <= 5; k++) begin
      in_valid = k < 5; in_r = W'(D + k); out_ready = k > 0;
      tick;
      if (int'(fifo_level) != D) err++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_level_errs", err, 0);
    chk("pushpop_overflow", int'(overflow), 0);
    err = 0;
    out_ready = 1'b1;
    for (int j = 0; j < D; j++) begin
      if (!out_valid || int'(out_r) != 5 + j) err++;
      tick;
    end
    chk("pushpop_drain_errs", err, 0);
    chk("pushpop_empty", int'(out_valid), 0);
    pulse_reset;
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_r = W'(1000 + k);
      tick;
      if (k == 16) chk("ovf_before_drop", int'(overflow), 0);
      if (k == 17) chk("ovf_rise", int'(overflow), 1);
    end
    in_valid = 1'b0;
    tick; tick;
    chk("ovf_level", int'(fifo_level), D);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_stall_head", int'(out_r), 1000);
    chk("ovf_stall_sop", int'(out_sop), 1);
    err = 0;
    out_ready = 1'b1;
    for (int j = 0; j < D; j++) begin
      if (!out_valid || int'(out_r) != 1000 + j) err++;
      tick;
    end
    chk("ovf_drain_errs", err, 0);
    chk("ovf_drain_empty", int'(out_valid), 0);
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; in_r = W'(c);
      tick;
    end
    pulse_reset;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_sym_idx", int'(sym_idx), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_sop", int'(out_sop), 1);
    tick;
    chk("midrst_no_inflight", int'(out_valid), 0);
    in_valid = 1'b1; in_r = W'(555);
    tick;
    in_valid = 1'b0;
    tick;
    chk("midrst_next_valid", int'(out_valid), 1);
    chk("midrst_next_sop", int'(out_sop), 1);
    chk("midrst_next_data", int'(out_r), 555);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pusch_sample_framer.md
# pusch_sample_framer

Output stage of the PUSCH transmit chain. It takes the time-domain samples (IFFT + cyclic prefix) from the PUSCH top level and does three things: scales and saturates them to DAC width, buffers them in a small FIFO, and delivers them on a valid/ready stream. The stream carries OFDM-symbol (sop/eop) and slot markers. The block absorbs backpressure from the RF/DAC interface and flags any sample lost to overflow.

## Interface
Parameters:
- WIDTH, 26: input sample width (signed, per I/Q)
- OUT_WIDTH, 16: output sample width (signed, per I/Q)
- FIFO_DEPTH, 16: FIFO entries; power of 2, at least 4
- SYM_LEN, 2192: samples per OFDM symbol including CP (2048 + 144)
- SYM_PER_SLOT, 14: symbols per slot

Ports:
- clk, in, 1: single clock
- reset, in, 1: synchronous, active-high
- in_valid, in, 1: input sample strobe (no ready; the upstream block cannot stall)
- in_r / in_i, in, WIDTH: signed input sample
- scale_shift, in, 5: arithmetic right shift, 0..WIDTH-1; sampled with each input
- out_ready, in, 1: downstream accepts sample
- out_valid, out, 1: output sample available
- out_r / out_i, out, OUT_WIDTH: signed output sample
- out_sop, out, 1: first sample of a symbol; qualified by out_valid
- out_eop, out, 1: last sample of a symbol; qualified by out_valid
- out_slot_end, out, 1: out_eop of the last symbol in the slot
- sym_idx, out, 4: index of the symbol currently being output, 0..SYM_PER_SLOT-1
- fifo_level, out, log2(FIFO_DEPTH)+1: number of occupied entries
- overflow, out, 1: sticky; set when a sample is dropped
- sat_count, out, 16: count of clipped samples (see Configuration)

## Operation
- Scaling stage (1 register):
  - When scale_shift > 0, compute x_s = (x + 2^(scale_shift-1)) >>> scale_shift, evaluated at WIDTH+1 bits. When scale_shift = 0, x_s = x.
  - Saturate x_s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - I and Q are handled independently. A sample counts as "clipped" if either component saturates.
- FIFO:
  - Synchronous, with show-ahead output. out_valid = not empty. Head data drives out_r/out_i directly.
  - Pop happens when out_valid && out_ready.
  - Push happens when the scaling stage holds a valid sample.
  - Push while full without a pop in the same cycle: the sample is dropped, overflow is set, FIFO contents are unchanged.
  - Push and pop in the same cycle while full: push is accepted and the level is unchanged.
  - Push and pop in the same cycle while empty: not possible, because there is no bypass (out_valid is 0).
- Framing counter (output side):
  - samp_cnt is 0..SYM_LEN-1 and advances only on a pop.
  - out_sop = (samp_cnt == 0). out_eop = (samp_cnt == SYM_LEN-1).
  - On a pop with eop, samp_cnt returns to 0 and sym_idx increments, wrapping from SYM_PER_SLOT-1 to 0.
  - out_slot_end = out_eop && sym_idx == SYM_PER_SLOT-1.
  - Dropped samples do not advance the counter. After an overflow, framing alignment is therefore not guaranteed, and overflow is the indication of that.
- Reset: all of the following return to 0:
  - FIFO pointers and level, scaling register
  - samp_cnt, sym_idx, overflow, sat_count
  - out_valid, out_r, out_i
  - out_sop = 1 combinationally from samp_cnt = 0, but it is qualified by out_valid = 0
  - out_eop = 0, out_slot_end = 0
  - Reset asserted mid-stream discards all buffered and in-flight samples. The next accepted sample is sop of symbol 0.

## Timing
- Latency: in_valid at cycle N puts the sample in the scaling register at N+1, writes it to the FIFO at the end of N+1, and gives out_valid at N+2 (FIFO empty, out_ready = 1).
- With out_ready held at 1 and an input rate of at most 1 sample/cycle, fifo_level stays at or below 1 and no overflow occurs.
- out_r, out_i, out_sop, out_eop, out_slot_end and sym_idx stay stable while out_valid && !out_ready.
- overflow rises in the cycle after the dropped push.
- fifo_level updates one cycle after the push/pop.

## Configuration
- SAT_CNT_EN defined: sat_count increments by 1 per clipped sample written into the FIFO (dropped samples are not counted). It saturates at 0xFFFF and is cleared by reset.
- SAT_CNT_EN undefined: the counter logic is absent and sat_count is tied to 0.

## Test plan
- Scaling/rounding: scale_shift = 4, in_r = 40 → out_r = 3. in_r = -40 → out_r = -2. in_r = 2^25-1 → out_r = 32767 and sat_count = 1 (with SAT_CNT_EN).
- Latency: FIFO empty, out_ready = 1, single in_valid at cycle 10 → out_valid for exactly one cycle at cycle 12, with out_sop = 1.
- Framing: 14 × 2192 samples, out_ready = 1 → eop every 2192 pops, sym_idx runs 0..13 and wraps, out_slot_end exactly once on pop 30688.
- Backpressure/overflow: out_ready = 0, 20 consecutive inputs with FIFO_DEPTH = 16 → fifo_level = 16, overflow = 1, then releasing out_ready yields exactly the first 16 samples in order.
- Full with simultaneous push/pop: fifo_level = 16, in_valid and out_ready both high → level stays at 16 and overflow stays 0.
- Reset mid-symbol: after 100 pops, pulse reset for 1 cycle → out_valid = 0, sym_idx = 0, overflow = 0, and the next sample has out_sop = 1.
